// File: rtl/v14_peak_finder.sv
`timescale 1ns/1ps
// v14_peak_finder: threshold pulse extractor behind the v14 trapezoidal filter.
// Optional pile-up rejection is compiled in when V14_PEAK_PILEUP_EN is defined.
`ifndef SIZE_FILTER_DATA
`define SIZE_FILTER_DATA 16
`endif

module v14_peak_finder #(
  parameter int DATA_W    = `SIZE_FILTER_DATA,
  parameter int THRESHOLD = 100,
  parameter int MIN_WIDTH = 4,
  parameter int MAX_WIDTH = 32,
  parameter int HOLDOFF   = 8,
  parameter int TS_W      = 32,
  parameter int WIDTH_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] filter_data,
  output logic                     event_valid,
  input  logic                     event_ready,
  output logic signed [DATA_W-1:0] event_amp,
  output logic [TS_W-1:0]          event_ts,
  output logic [WIDTH_W-1:0]       event_width,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              pileup_cnt
);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic signed [DATA_W-1:0] THR = DATA_W'(THRESHOLD);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [WIDTH_W-1:0] WIDTH_SAT = {WIDTH_W{1'b1}};
  localparam logic [WIDTH_W-1:0] MIN_W     = WIDTH_W'(MIN_WIDTH);

  typedef enum logic [1:0] {IDLE, PEAK, HOLD} state_t;

  state_t                     state, state_next;
  logic signed [DATA_W-1:0]   din_q, peak_amp;
  logic [TS_W-1:0]            ts_cnt, ts_q, peak_ts;
  logic [WIDTH_W-1:0]         width;
  logic [HOLD_W-1:0]          hold_cnt;
  logic                       pile_wait;
  logic                       above, issue, pile_hit;

  assign above = din_q > THR;

  // Input stage: sample and its timestamp travel together.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q  <= '0;
      ts_q   <= '0;
      ts_cnt <= '0;
    end else begin
      din_q  <= filter_data;
      ts_q   <= ts_cnt;
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE: if (above) state_next = PEAK;
      PEAK: begin
        if (pile_hit)            state_next = HOLD;
        else if (!above)
          if (width < MIN_W)     state_next = IDLE;
          else                   state_next = (HOLDOFF == 0) ? IDLE : HOLD;
      end
      HOLD: begin
        if (pile_wait) begin
          if (!above)            state_next = (HOLDOFF == 0) ? IDLE : HOLD;
        end else if (hold_cnt == HOLD_LAST) state_next = IDLE;
      end
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    issue    = (state == PEAK) && !above && (width >= MIN_W) && !pile_hit;
    pile_hit = 1'b0;
`ifdef V14_PEAK_PILEUP_EN
    // The (MAX_WIDTH+1)-th over-threshold sample marks a pile-up.
    pile_hit = (state == PEAK) && above && (32'(width) >= 32'(MAX_WIDTH));
`endif
  end

  // Pulse tracking: earliest maximum wins, width saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_amp  <= '0;
      peak_ts   <= '0;
      width     <= '0;
      hold_cnt  <= '0;
      pile_wait <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (above) begin
          peak_amp <= din_q;
          peak_ts  <= ts_q;
          width    <= WIDTH_W'(1);
        end
        PEAK: begin
          hold_cnt  <= '0;
          pile_wait <= pile_hit;
          if (above) begin
            if (width != WIDTH_SAT) width <= width + 1'b1;
            if (din_q > peak_amp) begin
              peak_amp <= din_q;
              peak_ts  <= ts_q;
            end
          end
        end
        HOLD: begin
          if (pile_wait) begin
            if (!above) pile_wait <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Single-entry output register; a new event may replace one leaving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_valid <= 1'b0;
      event_amp   <= '0;
      event_ts    <= '0;
      event_width <= '0;
      drop_cnt    <= '0;
    end else if (issue) begin
      if (!event_valid || event_ready) begin
        event_valid <= 1'b1;
        event_amp   <= peak_amp;
        event_ts    <= peak_ts;
        event_width <= width;
      end else if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end else if (event_valid && event_ready) begin
      event_valid <= 1'b0;
    end
  end

`ifdef V14_PEAK_PILEUP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                pileup_cnt <= '0;
    else if (pile_hit && pileup_cnt != 16'hFFFF) pileup_cnt <= pileup_cnt + 16'd1;
  end
`else
  assign pileup_cnt = 16'd0;
`endif

endmodule
